// File: rtl/vdisk_pkg.sv
// Shared definitions for the virtual-disk request arbiter: arbiter states,
// default channel, count and timeout sizes, and an index-width helper.
package vdisk_pkg;

    localparam int NDISK_DEF = 32'sd3;
    localparam int CNTW_DEF  = 32'sd6;
    localparam int TMO_DEF   = 32'sd16777216;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    // Width of a channel index; a single channel still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/vdisk_arb_if.sv
// Bundle of per-channel block-request and hps_io sector signals around the
// arbiter. The slave view belongs to the arbiter, the master view to its environment.
interface vdisk_arb_if import vdisk_pkg::*; #(
    parameter int NDISK = NDISK_DEF,
    parameter int CNTW  = CNTW_DEF
) ();

    logic [NDISK-1:0]      req_valid;
    logic [NDISK-1:0]      req_ready;
    logic [NDISK-1:0]      req_wr;
    logic [32*NDISK-1:0]   req_lba;
    logic [CNTW*NDISK-1:0] req_cnt;
    logic [NDISK-1:0]      req_done;
    logic [NDISK-1:0]      req_err;
    logic [NDISK-1:0]      img_mounted;
    logic                  img_size_nz;
    logic [32*NDISK-1:0]   sd_lba;
    logic [CNTW*NDISK-1:0] sd_blk_cnt;
    logic [NDISK-1:0]      sd_rd;
    logic [NDISK-1:0]      sd_wr;
    logic [NDISK-1:0]      sd_ack;
    logic                  active;

    modport slave (
        input  req_valid, req_wr, req_lba, req_cnt, img_mounted, img_size_nz, sd_ack,
        output req_ready, req_done, req_err, sd_lba, sd_blk_cnt, sd_rd, sd_wr, active
    );

    modport master (
        output req_valid, req_wr, req_lba, req_cnt, img_mounted, img_size_nz, sd_ack,
        input  req_ready, req_done, req_err, sd_lba, sd_blk_cnt, sd_rd, sd_wr, active
    );

endinterface

// File: rtl/vdisk_arb_rr_pick.sv
// Round-robin selector: picks the first requesting channel after the last
// granted one, wrapping around, and reports whether anything was picked.
module rr_pick import vdisk_pkg::*; #(
    parameter int N  = NDISK_DEF,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [IW-1:0] idx_s;

    // Walk the channels starting one past the last grant; the first hit wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx_s = '0;
        for (int k = 32'sd0; k < N; k++) begin
            idx_s        = IW'((int'(last) + k + 32'sd1) % N);
            grant[idx_s] = req[idx_s] & ~valid;
            valid        = valid | req[idx_s];
        end
    end

endmodule

// File: rtl/vdisk_arb.sv
// Arbiter sharing one hps_io sector port among NDISK virtual-disk channels:
// one outstanding transfer at a time, with timeout and mount tracking.
module vdisk_arb import vdisk_pkg::*; #(
    parameter int NDISK = NDISK_DEF,
    parameter int CNTW  = CNTW_DEF,
    parameter int TMO   = TMO_DEF
) (
    input logic        clk_sys,
    input logic        reset_n,
    vdisk_arb_if.slave bus
);

    localparam int IW = idx_width(NDISK);
    localparam int TW = $clog2(TMO) + 32'sd1;
    localparam logic [NDISK-1:0] ONE = NDISK'(1'b1);

    state_e            state_r, state_n;
    logic [IW-1:0]     g_r, ptr_r, pick_idx_s, gn_s;
    logic [NDISK-1:0]  pick_req_s, pick_grant_s, g_oh_s;
    logic              pick_valid_s;
    logic [NDISK-1:0]  mounted_r, blk_r;
    logic              wr_r [NDISK];
    logic [31:0]       lba_r [NDISK];
    logic [CNTW-1:0]   cnt_r [NDISK];
    logic [TW-1:0]     tmo_r;
    logic              err_pend_r, active_r;
    logic [NDISK-1:0]  ready_r, done_r, err_r, sd_rd_r, sd_wr_r;
    logic              go_grant_s, ack_g_s, unmount_g_s, tmo_hit_s;
    logic              abort_s, timeout_s, finish_s, wr_n_s;

    // A channel whose previous request timed out stays unpickable until its stale ack falls.
    assign pick_req_s = bus.req_valid & ~blk_r;
    assign g_oh_s     = ONE << g_r;

    rr_pick #(.N(NDISK), .IW(IW)) u_pick (
        .req   (pick_req_s),
        .last  (ptr_r),
        .grant (pick_grant_s),
        .valid (pick_valid_s)
    );

    // One-hot grant to channel index.
    always_comb begin
        pick_idx_s = '0;
        for (int i = 32'sd0; i < NDISK; i++) begin
            pick_idx_s = pick_idx_s | (pick_grant_s[i] ? IW'(i) : {IW{1'b0}});
        end
    end

    // Next-state logic and per-cycle transition events.
    always_comb begin
        state_n     = state_r;
        go_grant_s  = 1'b0;
        abort_s     = 1'b0;
        timeout_s   = 1'b0;
        finish_s    = 1'b0;
        ack_g_s     = bus.sd_ack[g_r] & ~blk_r[g_r];
        unmount_g_s = bus.img_mounted[g_r] & ~bus.img_size_nz;
        tmo_hit_s   = (tmo_r == TW'(TMO - 32'sd1));
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    go_grant_s = 1'b1;
                    state_n    = mounted_r[pick_idx_s] ? ST_ISSUE : ST_FIN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (unmount_g_s) begin
                    abort_s = 1'b1;
                    state_n = ST_FIN;
                end else if (ack_g_s) begin
                    state_n = ST_XFER;
                end else if (tmo_hit_s) begin
                    timeout_s = 1'b1;
                    state_n   = ST_IDLE;
                end else begin
                    state_n = ST_ISSUE;
                end
            end
            ST_XFER: begin
                if (unmount_g_s) begin
                    abort_s = 1'b1;
                    state_n = ST_FIN;
                end else if (!bus.sd_ack[g_r]) begin
                    state_n = ST_FIN;
                end else begin
                    state_n = ST_XFER;
                end
            end
            ST_FIN: begin
                finish_s = 1'b1;
                state_n  = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        gn_s   = go_grant_s ? pick_idx_s : g_r;
        wr_n_s = go_grant_s ? bus.req_wr[pick_idx_s] : wr_r[g_r];
    end

    // FSM state, grant bookkeeping, timeout counter and registered strobes/pulses.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            g_r        <= '0;
            ptr_r      <= IW'(NDISK - 32'sd1);
            tmo_r      <= '0;
            err_pend_r <= 1'b0;
            ready_r    <= '0;
            done_r     <= '0;
            err_r      <= '0;
            sd_rd_r    <= '0;
            sd_wr_r    <= '0;
            active_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            ready_r <= go_grant_s ? pick_grant_s : '0;
            if (go_grant_s) begin
                g_r        <= pick_idx_s;
                ptr_r      <= pick_idx_s;
                err_pend_r <= ~mounted_r[pick_idx_s];
            end else if (abort_s) begin
                err_pend_r <= 1'b1;
            end
            tmo_r   <= (state_r == ST_ISSUE && state_n == ST_ISSUE) ? tmo_r + TW'(1'b1) : '0;
            done_r  <= (finish_s || timeout_s) ? g_oh_s : '0;
            err_r   <= (timeout_s || (finish_s && err_pend_r)) ? g_oh_s : '0;
            sd_rd_r <= '0;
            sd_wr_r <= '0;
            if (state_n == ST_ISSUE) begin
                sd_rd_r[gn_s] <= ~wr_n_s;
                sd_wr_r[gn_s] <= wr_n_s;
            end
            active_r <= (state_n == ST_ISSUE) || (state_n == ST_XFER);
        end
    end

    // Mount flags follow each mount pulse; the stale-ack block is armed by a timeout.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mounted_r <= '0;
            blk_r     <= '0;
        end else begin
            mounted_r <= (mounted_r & ~bus.img_mounted) | (bus.img_mounted & {NDISK{bus.img_size_nz}});
            blk_r     <= (blk_r & bus.sd_ack) | (timeout_s ? g_oh_s : '0);
        end
    end

    // Per-channel request registers, captured on that channel's grant.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 32'sd0; i < NDISK; i++) begin
                wr_r[i]  <= 1'b0;
                lba_r[i] <= '0;
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 32'sd0; i < NDISK; i++) begin
                if (go_grant_s && pick_grant_s[i]) begin
                    wr_r[i]  <= bus.req_wr[i];
                    lba_r[i] <= bus.req_lba[32*i +: 32];
                    cnt_r[i] <= bus.req_cnt[CNTW*i +: CNTW];
                end
            end
        end
    end

    for (genvar i = 0; i < NDISK; i++) begin : g_out
        assign bus.sd_lba[32*i +: 32]       = lba_r[i];
        assign bus.sd_blk_cnt[CNTW*i +: CNTW] = cnt_r[i];
    end

    assign bus.req_ready = ready_r;
    assign bus.req_done  = done_r;
    assign bus.req_err   = err_r;
    assign bus.sd_rd     = sd_rd_r;
    assign bus.sd_wr     = sd_wr_r;
    assign bus.active    = active_r;

endmodule

// File: tb/tb_vdisk_arb.sv
// Directed bench for vdisk_arb: grants and completions are checked against
// queues of expected events filled as each request is driven.
module tb_vdisk_arb;
    import vdisk_pkg::*;

    localparam int N     = 3;
    localparam int CW    = 6;
    localparam int TMO_T = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vdisk_arb_if #(.NDISK(N), .CNTW(CW)) bus ();

    vdisk_arb #(.NDISK(N), .CNTW(CW), .TMO(TMO_T)) dut (
        .clk_sys (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct { int ch; logic err; } done_t;

    done_t done_q[$];
    int    gnt_q[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    issued[N]   = '{default: 0};
    int    granted[N]  = '{default: 0};
    int    done_cnt[N] = '{default: 0};
    int    rd1_cnt = 0;
    int    wr2_cnt = 0;
    int    mon_e;
    done_t mon_d;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = no completion expected, 1 = done ok, 2 = done with err
    task automatic req(input int ch, input logic wr, input logic [31:0] lba,
                       input logic [CW-1:0] cnt, input int kind);
        bus.req_wr[ch]             = wr;
        bus.req_lba[32*ch +: 32]   = lba;
        bus.req_cnt[CW*ch +: CW]   = cnt;
        gnt_q.push_back(ch);
        if (kind != 0) done_q.push_back('{ch, (kind == 2)});
        issued[ch]++;
    endtask

    // Requesters hold valid until each of their requests has been accepted.
    always_comb begin
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) bus.req_valid[i] = (issued[i] != granted[i]);
    end

    // Mid-cycle monitor: strobe counts, grant order and completion scoreboard.
    always @(negedge clk) begin
        if (bus.sd_rd[1]) rd1_cnt++;
        if (bus.sd_wr[2]) wr2_cnt++;
        if ((bus.sd_rd | bus.sd_wr) != '0) check("strobe_onehot", $onehot(bus.sd_rd | bus.sd_wr), 1);
        if (bus.req_ready != '0) begin
            for (int i = 0; i < N; i++) if (bus.req_ready[i]) granted[i]++;
            if (gnt_q.size() == 0) check("ready_unexpected", bus.req_ready, 0);
            else begin
                mon_e = gnt_q.pop_front();
                check("grant_order", bus.req_ready, 3'b001 << mon_e);
            end
        end
        if (bus.req_done != '0) begin
            for (int i = 0; i < N; i++) if (bus.req_done[i]) done_cnt[i]++;
            if (done_q.size() == 0) check("done_unexpected", bus.req_done, 0);
            else begin
                mon_d = done_q.pop_front();
                check("done_ch", bus.req_done, 3'b001 << mon_d.ch);
                check("done_err", bus.req_err, mon_d.err ? (3'b001 << mon_d.ch) : 3'b000);
            end
        end else if (bus.req_err != '0) begin
            check("err_without_done", bus.req_err, 0);
        end
    end

    initial begin
        int n;
        bus.req_wr      = '0;
        bus.req_lba     = '0;
        bus.req_cnt     = '0;
        bus.img_mounted = '0;
        bus.img_size_nz = 1'b0;
        bus.sd_ack      = '0;
        repeat (3) tick();
        check("rst_ready", bus.req_ready, 0);
        check("rst_done", bus.req_done, 0);
        check("rst_err", bus.req_err, 0);
        check("rst_strobes", {bus.sd_rd, bus.sd_wr}, 0);
        check("rst_active", bus.active, 0);
        check("rst_lba_cnt", {bus.sd_lba, bus.sd_blk_cnt}, 0);
        rst_n = 1'b1;
        tick();

        // Round robin from reset pointer 2; all channels still unmounted.
        req(0, 1'b0, 32'h10, 6'd0, 2);
        req(1, 1'b0, 32'h11, 6'd0, 2);
        req(2, 1'b0, 32'h12, 6'd0, 2);
        req(0, 1'b0, 32'h13, 6'd0, 2);
        repeat (20) tick();
        check("t044_grants_drained", gnt_q.size(), 0);
        check("t044_dones_drained", done_q.size(), 0);
        check("t044_valid_clear", bus.req_valid, 0);

        bus.img_size_nz = 1'b1;
        bus.img_mounted = 3'b011;
        tick();
        bus.img_mounted = 3'b000;
        bus.img_size_nz = 1'b0;

        // Normal read on channel 1.
        rd1_cnt = 0;
        done_cnt[1] = 0;
        req(1, 1'b0, 32'h100, 6'd0, 1);
        tick();
        check("t043_rd_strobe", {bus.sd_rd, bus.sd_wr}, 6'b010_000);
        check("t043_lba", bus.sd_lba[63:32], 32'h100);
        check("t043_cnt", bus.sd_blk_cnt[11:6], 6'd0);
        check("t043_active", bus.active, 1);
        repeat (2) tick();
        bus.sd_ack[1] = 1'b1;
        repeat (10) tick();
        bus.sd_ack[1] = 1'b0;
        n = 0;
        while (!bus.req_done[1] && n < 40) begin
            tick();
            n++;
        end
        check("t043_done_seen", bus.req_done[1], 1);
        check("t043_err", bus.req_err[1], 0);
        tick();
        check("t043_rd_cycles", rd1_cnt, 3);
        check("t043_done_count", done_cnt[1], 1);
        check("t043_idle", bus.active, 0);

        // Write to unmounted channel 2: completes with error, no strobe.
        wr2_cnt = 0;
        req(2, 1'b1, 32'h2000, 6'd5, 2);
        tick();
        check("t045_ready", bus.req_ready, 3'b100);
        tick();
        check("t045_done", bus.req_done, 3'b100);
        check("t045_err", bus.req_err, 3'b100);
        tick();
        check("t045_no_wr", wr2_cnt, 0);

        // Timeout with TMO = 16, then a late ack.
        rd1_cnt = 0;
        done_cnt[1] = 0;
        req(1, 1'b0, 32'h55, 6'd3, 2);
        tick();
        repeat (15) tick();
        check("t046_strobe_c15", bus.sd_rd, 3'b010);
        tick();
        check("t046_strobe_c16", bus.sd_rd, 3'b000);
        check("t046_done", bus.req_done, 3'b010);
        check("t046_err", bus.req_err, 3'b010);
        check("t046_rd_cycles", rd1_cnt, 16);
        repeat (3) tick();
        bus.sd_ack[1] = 1'b1;
        repeat (2) tick();
        bus.sd_ack[1] = 1'b0;
        repeat (8) tick();
        check("t046_single_done", done_cnt[1], 1);
        check("t046_no_restrobe", rd1_cnt, 16);

        // Eject channel 0 during its transfer.
        req(0, 1'b0, 32'h777, 6'd1, 2);
        tick();
        check("t047_rd_strobe", bus.sd_rd, 3'b001);
        tick();
        bus.sd_ack[0] = 1'b1;
        tick();
        check("t047_xfer_strobe", bus.sd_rd, 3'b000);
        check("t047_xfer_active", bus.active, 1);
        bus.img_size_nz = 1'b0;
        bus.img_mounted = 3'b001;
        tick();
        bus.img_mounted = 3'b000;
        check("t047_abort_active", bus.active, 0);
        tick();
        check("t047_done", bus.req_done, 3'b001);
        check("t047_err", bus.req_err, 3'b001);
        bus.sd_ack[0] = 1'b0;
        tick();
        req(0, 1'b0, 32'h10, 6'd0, 2);
        tick();
        check("t047_unmounted_ready", bus.req_ready, 3'b001);
        check("t047_unmounted_no_rd", bus.sd_rd, 3'b000);
        tick();
        check("t047_unmounted_done", bus.req_done, 3'b001);
        check("t047_unmounted_err", bus.req_err, 3'b001);
        tick();

        // Reset in the middle of a write transfer on channel 1.
        req(1, 1'b1, 32'hABC, 6'd7, 0);
        tick();
        check("t048_wr_strobe", bus.sd_wr, 3'b010);
        bus.sd_ack[1] = 1'b1;
        repeat (2) tick();
        check("t048_xfer_active", bus.active, 1);
        rst_n = 1'b0;
        #1;
        check("t048_rst_strobes", {bus.sd_rd, bus.sd_wr}, 0);
        check("t048_rst_active", bus.active, 0);
        check("t048_rst_pulses", {bus.req_ready, bus.req_done, bus.req_err}, 0);
        check("t048_rst_lba_cnt", {bus.sd_lba, bus.sd_blk_cnt}, 0);
        bus.sd_ack[1] = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("t048_post_idle", bus.active, 0);
        req(1, 1'b0, 32'h1, 6'd0, 2);
        tick();
        check("t048_post_ready", bus.req_ready, 3'b010);
        check("t048_post_no_rd", bus.sd_rd, 3'b000);
        tick();
        check("t048_post_done", bus.req_done, 3'b010);
        check("t048_post_err", bus.req_err, 3'b010);

        repeat (5) tick();
        check("end_grants_drained", gnt_q.size(), 0);
        check("end_dones_drained", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
